// File: rtl/branch_history_fifo.sv
// branch_history_fifo: holds GHR snapshots of in-flight branches; pops at resolution drive counter update and history repair
module branch_history_fifo #(
  parameter int BPRED_WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_DEC_Is_Branch,
  input  logic [BPRED_WIDTH-1:0] i_Global_History,
  input  logic                   i_Prediction,
  input  logic                   i_ALU_Branch_Valid,
  input  logic                   i_ALU_Branch_Outcome,
  output logic                   o_Update_Valid,
  output logic [BPRED_WIDTH-1:0] o_Update_Index,
  output logic                   o_Update_Taken,
  output logic                   o_Mispredict,
  output logic [BPRED_WIDTH-1:0] o_Restore_History,
  output logic [$clog2(DEPTH):0] o_Count,
  output logic                   o_Empty,
  output logic                   o_Full,
  output logic                   o_Error
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [BPRED_WIDTH-1:0] GHR_RST = BPRED_WIDTH'(1);
  logic [BPRED_WIDTH-1:0] hist_mem [DEPTH];
  logic                   pred_mem [DEPTH];
  logic [AW-1:0]          rd_ptr, wr_ptr, rd_next;
  logic [AW:0]            count;
  logic                   pop_ok, push_ok, mis, err_set;
  assign o_Count = count;
  assign o_Empty = count == '0;
  assign o_Full  = count == FULL_CNT;
  assign rd_next = rd_ptr + AW'(1);
  assign pop_ok  = i_ALU_Branch_Valid && !o_Empty;
  assign mis     = pop_ok && (pred_mem[rd_ptr] != i_ALU_Branch_Outcome);
  // a push alongside a mispredicting pop is wrong-path and silently dropped
  assign push_ok = i_DEC_Is_Branch && (!o_Full || pop_ok) && !mis;
  assign err_set = (i_DEC_Is_Branch && o_Full && !pop_ok) || (i_ALU_Branch_Valid && o_Empty);
  // entry storage; no reset needed since occupancy gates every read
  always_ff @(posedge i_Clk) begin
    if (push_ok) begin
      hist_mem[wr_ptr] <= i_Global_History;
      pred_mem[wr_ptr] <= i_Prediction;
    end
  end
  // pointers and occupancy; a mispredict squashes every younger entry
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mis) begin
      rd_ptr <= rd_next;
      wr_ptr <= rd_next;
      count  <= '0;
    end else begin
      rd_ptr <= pop_ok ? rd_next : rd_ptr;
      wr_ptr <= push_ok ? wr_ptr + AW'(1) : wr_ptr;
      count  <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end
  // registered update/repair outputs; data fields hold between pops
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      o_Update_Valid    <= 1'b0;
      o_Mispredict      <= 1'b0;
      o_Update_Taken    <= 1'b0;
      o_Update_Index    <= '0;
      o_Restore_History <= GHR_RST;
    end else begin
      o_Update_Valid <= pop_ok;
      o_Mispredict   <= mis;
      if (pop_ok) begin
        o_Update_Taken    <= i_ALU_Branch_Outcome;
        o_Update_Index    <= hist_mem[rd_ptr];
        o_Restore_History <= {hist_mem[rd_ptr][BPRED_WIDTH-2:0], i_ALU_Branch_Outcome};
      end
    end
  end
  // sticky overflow/underflow flag
  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) o_Error <= 1'b0;
    else if (err_set) o_Error <= 1'b1;
  end
endmodule

// File: tb/tb_branch_history_fifo.sv
// tb_branch_history_fifo: directed checks of push/pop, mispredict squash, full/empty boundaries and wrap
module tb_branch_history_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       is_branch = 1'b0;
  logic [8:0] ghist = '0;
  logic       pred = 1'b0;
  logic       alu_valid = 1'b0;
  logic       outcome = 1'b0;
  logic       upd_valid, upd_taken, mispredict, empty, full, error;
  logic [8:0] upd_index, restore;
  logic [2:0] count;
  int tests = 0;
  int fails = 0;

  branch_history_fifo #(.BPRED_WIDTH(9), .DEPTH(4)) dut (
    .i_Clk(clk), .i_Reset(rst_n),
    .i_DEC_Is_Branch(is_branch), .i_Global_History(ghist), .i_Prediction(pred),
    .i_ALU_Branch_Valid(alu_valid), .i_ALU_Branch_Outcome(outcome),
    .o_Update_Valid(upd_valid), .o_Update_Index(upd_index), .o_Update_Taken(upd_taken),
    .o_Mispredict(mispredict), .o_Restore_History(restore), .o_Count(count),
    .o_Empty(empty), .o_Full(full), .o_Error(error)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    is_branch = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b exp 1", empty); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b exp 0", full); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d exp 0", count); end
    tests++; if (upd_valid !== 1'b0) begin fails++; $display("FAIL reset_upd_valid: got %b exp 0", upd_valid); end
    tests++; if (restore !== 9'h001) begin fails++; $display("FAIL reset_restore: got %h exp 001", restore); end
    tests++; if (upd_index !== 9'h000) begin fails++; $display("FAIL reset_index: got %h exp 000", upd_index); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b exp 0", error); end
  endtask

  task automatic test_correct_pred();
    is_branch = 1'b1; ghist = 9'h0A5; pred = 1'b1;
    step();
    idle();
    tests++; if (count !== 3'd1) begin fails++; $display("FAIL cp_count_push: got %0d exp 1", count); end
    step();
    step();
    alu_valid = 1'b1; outcome = 1'b1;
    step();
    idle();
    tests++; if (upd_valid !== 1'b1) begin fails++; $display("FAIL cp_valid: got %b exp 1", upd_valid); end
    tests++; if (upd_index !== 9'h0A5) begin fails++; $display("FAIL cp_index: got %h exp 0a5", upd_index); end
    tests++; if (upd_taken !== 1'b1) begin fails++; $display("FAIL cp_taken: got %b exp 1", upd_taken); end
    tests++; if (mispredict !== 1'b0) begin fails++; $display("FAIL cp_mispredict: got %b exp 0", mispredict); end
    tests++; if (restore !== 9'h14B) begin fails++; $display("FAIL cp_restore: got %h exp 14b", restore); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL cp_count: got %0d exp 0", count); end
    step();
    tests++; if (upd_valid !== 1'b0) begin fails++; $display("FAIL cp_valid_drop: got %b exp 0", upd_valid); end
    tests++; if (upd_index !== 9'h0A5) begin fails++; $display("FAIL cp_index_hold: got %h exp 0a5", upd_index); end
  endtask

  task automatic test_mispredict();
    is_branch = 1'b1;
    ghist = 9'h001; pred = 1'b0; step();
    ghist = 9'h002; pred = 1'b1; step();
    ghist = 9'h005; pred = 1'b1; step();
    tests++; if (count !== 3'd3) begin fails++; $display("FAIL mp_count_fill: got %0d exp 3", count); end
    ghist = 9'h00B; pred = 1'b1; alu_valid = 1'b1; outcome = 1'b1;
    step();
    idle();
    tests++; if (mispredict !== 1'b1) begin fails++; $display("FAIL mp_mispredict: got %b exp 1", mispredict); end
    tests++; if (upd_valid !== 1'b1) begin fails++; $display("FAIL mp_valid: got %b exp 1", upd_valid); end
    tests++; if (restore !== 9'h003) begin fails++; $display("FAIL mp_restore: got %h exp 003", restore); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL mp_count: got %0d exp 0", count); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL mp_error: got %b exp 0", error); end
    step();
    tests++; if (mispredict !== 1'b0) begin fails++; $display("FAIL mp_mispredict_drop: got %b exp 0", mispredict); end
    is_branch = 1'b1; ghist = 9'h010; pred = 1'b1; step();
    is_branch = 1'b0; alu_valid = 1'b1; outcome = 1'b1; step();
    idle();
    tests++; if (upd_index !== 9'h010) begin fails++; $display("FAIL mp_after_squash_index: got %h exp 010", upd_index); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL mp_after_squash_count: got %0d exp 0", count); end
  endtask

  task automatic test_full();
    logic [8:0] exp_q [4];
    exp_q[0] = 9'h011; exp_q[1] = 9'h012; exp_q[2] = 9'h013; exp_q[3] = 9'h015;
    do_reset();
    is_branch = 1'b1; pred = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ghist = 9'h010 + 9'(i);
      step();
    end
    idle();
    tests++; if (full !== 1'b1) begin fails++; $display("FAIL full_flag: got %b exp 1", full); end
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_count: got %0d exp 4", count); end
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL full_error_pre: got %b exp 0", error); end
    is_branch = 1'b1; ghist = 9'h014; step();
    idle();
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL full_overflow_error: got %b exp 1", error); end
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_overflow_count: got %0d exp 4", count); end
    is_branch = 1'b1; ghist = 9'h015; alu_valid = 1'b1; outcome = 1'b1; step();
    idle();
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL full_pushpop_count: got %0d exp 4", count); end
    tests++; if (upd_index !== 9'h010) begin fails++; $display("FAIL full_pushpop_index: got %h exp 010", upd_index); end
    tests++; if (mispredict !== 1'b0) begin fails++; $display("FAIL full_pushpop_mispredict: got %b exp 0", mispredict); end
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; outcome = 1'b1; step();
      tests++; if (upd_index !== exp_q[i]) begin fails++; $display("FAIL full_drain_%0d: got %h exp %h", i, upd_index, exp_q[i]); end
    end
    idle();
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL full_drain_empty: got %b exp 1", empty); end
  endtask

  task automatic test_wrap();
    int popped = 0;
    do_reset();
    pred = 1'b1; outcome = 1'b1;
    is_branch = 1'b1; ghist = 9'h100; step();
    is_branch = 1'b1; ghist = 9'h101; step();
    for (int i = 2; i < 12; i++) begin
      is_branch = i < 10; ghist = 9'h100 + 9'(i);
      alu_valid = 1'b1; step();
      tests++; if (upd_valid !== 1'b1 || upd_index !== 9'h100 + 9'(popped)) begin fails++; $display("FAIL wrap_%0d: got v=%b idx=%h exp v=1 idx=%h", popped, upd_valid, upd_index, 9'h100 + 9'(popped)); end
      popped++;
      if (i < 10) begin
        tests++; if (count !== 3'd2) begin fails++; $display("FAIL wrap_count_%0d: got %0d exp 2", i, count); end
      end
    end
    idle();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL wrap_final_count: got %0d exp 0", count); end
  endtask

  task automatic test_underflow();
    do_reset();
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL uf_error_pre: got %b exp 0", error); end
    alu_valid = 1'b1; outcome = 1'b0; step();
    idle();
    tests++; if (upd_valid !== 1'b0) begin fails++; $display("FAIL uf_valid: got %b exp 0", upd_valid); end
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL uf_error: got %b exp 1", error); end
    step(); step(); step();
    tests++; if (error !== 1'b1) begin fails++; $display("FAIL uf_error_sticky: got %b exp 1", error); end
    rst_n = 1'b0; #1;
    tests++; if (error !== 1'b0) begin fails++; $display("FAIL uf_error_reset: got %b exp 0", error); end
    rst_n = 1'b1; step();
  endtask

  task automatic test_async_reset();
    do_reset();
    is_branch = 1'b1; pred = 1'b1; ghist = 9'h0F0; step();
    ghist = 9'h0F1; alu_valid = 1'b1; outcome = 1'b1; step();
    idle();
    #2 rst_n = 1'b0; #1;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL ar_count: got %0d exp 0", count); end
    tests++; if (upd_valid !== 1'b0) begin fails++; $display("FAIL ar_valid: got %b exp 0", upd_valid); end
    tests++; if (restore !== 9'h001) begin fails++; $display("FAIL ar_restore: got %h exp 001", restore); end
    rst_n = 1'b1; step();
    alu_valid = 1'b1; step();
    idle();
    tests++; if (upd_valid !== 1'b0) begin fails++; $display("FAIL ar_no_stale_pop: got %b exp 0", upd_valid); end
  endtask

  initial begin
    test_reset();
    test_correct_pred();
    test_mispredict();
    test_full();
    test_wrap();
    test_underflow();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_history_fifo.md
BRANCH_HISTORY_FIFO -- requirements
Module: branch_history_fifo

Interface
REQ-001 Parameter BPRED_WIDTH, default 9, SHALL set the width of the global history snapshot.
REQ-002 Parameter DEPTH, default 4, SHALL set the number of in-flight branch entries; it SHALL be a power of two, 2..16.
REQ-003 i_Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 i_Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 i_DEC_Is_Branch  input  1  SHALL mean a branch at DEC; this is the push request.
REQ-006 i_Global_History  input  BPRED_WIDTH  SHALL carry the GHR value seen by the DEC branch, captured before its prediction is inserted.
REQ-007 i_Prediction  input  1  SHALL carry the prediction given to the DEC branch (1 = taken).
REQ-008 i_ALU_Branch_Valid  input  1  SHALL mean a branch resolved at EX; this is the pop request.
REQ-009 i_ALU_Branch_Outcome  input  1  SHALL carry the resolved direction (1 = taken).
REQ-010 o_Update_Valid  output  1  SHALL pulse for one cycle when a counter-table update is presented.
REQ-011 o_Update_Index  output  BPRED_WIDTH  SHALL give the popped snapshot, used as the counter-table index.
REQ-012 o_Update_Taken  output  1  SHALL give the resolved outcome for the counter update.
REQ-013 o_Mispredict  output  1  SHALL pulse when the popped prediction differs from the outcome.
REQ-014 o_Restore_History  output  BPRED_WIDTH  SHALL give the corrected GHR value: {snapshot[BPRED_WIDTH-2:0], outcome}.
REQ-015 o_Count  output  log2(DEPTH)+1  SHALL give the current occupancy.
REQ-016 o_Empty / o_Full  output  1 each  SHALL be combinational decodes: count==0 and count==DEPTH.
REQ-017 o_Error  output  1  SHALL be a sticky flag for overflow or underflow.

Function
REQ-018 Storage SHALL be a circular buffer of DEPTH entries {snapshot, prediction}, with read and write pointers that wrap modulo DEPTH.
REQ-019 Push SHALL be accepted when i_DEC_Is_Branch=1 and (count<DEPTH or a pop is accepted in the same cycle).
- Entry written at the write pointer.
- Write pointer then increments.
REQ-020 Pop SHALL be accepted when i_ALU_Branch_Valid=1 and count>0; the entry at the read pointer is consumed and the read pointer increments.
REQ-021 Update outputs SHALL be registered with latency 1: a pop accepted at edge N drives o_Update_Valid, o_Update_Index, o_Update_Taken, o_Mispredict and o_Restore_History during cycle N..N+1.
- o_Update_Valid and o_Mispredict return to 0 the next cycle unless another pop occurs.
- The data outputs hold their last value.
REQ-022 Simultaneous push and pop with no mispredict SHALL leave count unchanged; this is legal at full and at empty+1.
REQ-023 A pop whose prediction differs from the outcome SHALL squash all younger entries: count becomes 0 and the write pointer is set equal to the new read pointer.
REQ-024 A push in the same cycle as a mispredicting pop SHALL be discarded, because it is wrong-path; o_Error is not set.
REQ-025 Push when full without a pop SHALL be dropped and SHALL set o_Error; contents are unchanged.
REQ-026 Pop when empty SHALL be ignored (no o_Update_Valid) and SHALL set o_Error.
REQ-027 o_Error SHALL clear only on reset.
REQ-028 No combinational path SHALL exist from any input to o_Update_* or o_Mispredict.

Reset
REQ-029 While i_Reset=0, the block SHALL asynchronously set:
- pointers=0, count=0, o_Empty=1, o_Full=0
- o_Update_Valid=0, o_Mispredict=0, o_Update_Taken=0, o_Error=0
- o_Update_Index=0, o_Restore_History='h001 (matches the GHR reset value).
REQ-030 Reset asserted mid-operation SHALL discard all entries and any pending update within the same cycle; storage contents need not be cleared.

Verification
REQ-031 Reset check: after deassertion -> o_Empty=1, o_Count=0, o_Update_Valid=0, o_Restore_History=9'h001, o_Error=0.
REQ-032 Correct prediction: push {hist=9'h0A5, pred=1}; two cycles later pop with outcome=1 -> one cycle after the pop, o_Update_Valid=1, o_Update_Index=9'h0A5, o_Update_Taken=1, o_Mispredict=0, o_Restore_History=9'h14B; count returns to 0.
REQ-033 Mispredict squash: push three entries (9'h001/pred 0, 9'h002/pred 1, 9'h005/pred 1); pop with outcome=1 and push 9'h00B in the same cycle -> o_Mispredict=1, o_Restore_History=9'h003, o_Count=0, the same-cycle push dropped, o_Error=0.
REQ-034 Full boundary: push DEPTH=4 entries -> o_Full=1; then:
- a fifth push alone -> dropped, o_Error=1;
- push+pop together with a correct prediction -> o_Count stays 4;
- pops then return entries in FIFO order.
REQ-035 Wrap-around: push and pop 10 entries with correct predictions over 2-entry occupancy -> every o_Update_Index matches push order across pointer wrap.
REQ-036 Underflow: pop while empty -> no o_Update_Valid pulse, o_Error=1, and it remains 1 until i_Reset=0.
